flash_read_ctrl: RTL and testbench
==================================

# flash_read_ctrl

Responder side of the sample-fetch handshake. Accepts a one-word read request (start, 23-bit word address, byte enables) from the address/playback sequencer, runs a single-beat Avalon-MM pipelined read against the flash controller, and returns the 32-bit word with a one-cycle `done` pulse. It sits between the sequencer and the flash IP's memory-mapped slave port.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024, maximum cycles spent in `WAIT_DATA` before an aborted read; used only with `FLASH_RD_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  read request; level, held by the requester until `done`.
- `address`  in  23  flash word address; sampled when the request is accepted.
- `byteenable`  in  4  byte lanes; sampled with `address`.
- `done`  out  1  one-cycle pulse; `data` is valid from this cycle onward.
- `data`  out  32  last word read; held until the next `done`.
- `err`  out  1  high with `done` when the read timed out; constant 0 without the macro.
- `flash_mem_read`  out  1  Avalon read command.
- `flash_mem_address`  out  23  Avalon address (latched copy of `address`).
- `flash_mem_byteenable`  out  4  latched copy of `byteenable`.
- `flash_mem_burstcount`  out  6  constant 1.
- `flash_mem_waitrequest`  in  1  slave stall.
- `flash_mem_readdata`  in  32  read data.
- `flash_mem_readdatavalid`  in  1  read data qualifier.

## Operation
- States: `IDLE`, `REQ`, `WAIT_DATA`, `DONE`.
- `IDLE`: if `start`=1, latch `address`/`byteenable` into the command registers and go to `REQ`; otherwise stay.
- `REQ`: `flash_mem_read`=1 with latched address/byteenable. If `flash_mem_waitrequest`=0, the command is accepted -> `WAIT_DATA`; otherwise stay, holding the command stable.
- `WAIT_DATA`: `flash_mem_read`=0. On `flash_mem_readdatavalid`=1, load `data` <= `flash_mem_readdata` and go to `DONE`.
- `DONE`: `done`=1 for exactly this cycle -> `IDLE`.
- `readdatavalid` in any state other than `WAIT_DATA` is ignored; `data` does not change.
- If `start` is still high in `IDLE` after `DONE`, a new read is issued (back-to-back reads are legal).
- `address`/`byteenable` changes after acceptance do not affect the in-flight read.
- `start` dropping mid-read does not abort it; the read completes and `done` pulses.

## Timing
- Reset values: state `IDLE`; `done`=0, `err`=0, `data`=0, `flash_mem_read`=0, `flash_mem_address`=0, `flash_mem_byteenable`=0; `flash_mem_burstcount`=1 always.
- Reset asserted mid-read: immediate return to `IDLE`, `flash_mem_read` deasserted; any late `readdatavalid` after reset is ignored.
- Minimum latency: `start` sampled at edge 0 -> `flash_mem_read` high in cycle 1 -> with zero waitrequest and `readdatavalid` in cycle 2, `done` high in cycle 3.
- Each waitrequest cycle and each readdatavalid-wait cycle adds exactly one cycle.
- `data` and `done` are registered outputs; `flash_mem_*` outputs are registered.

## Configuration
- `FLASH_RD_TIMEOUT_EN` defined: a counter clears on entry to `WAIT_DATA` and increments each cycle there. When it reaches `TIMEOUT_CYCLES` without `readdatavalid`, go to `DONE` with `data` unchanged and `err`=1 during the `done` cycle. A response arriving in the same cycle as the timeout wins: normal completion, `err`=0.
- Not defined: no counter; `WAIT_DATA` waits indefinitely; `err` tied 0.

## Structure
- Package `flash_rd_pkg`: state enum `flash_rd_state_t`, `FLASH_ADDR_W`=23, `FLASH_DATA_W`=32, `FLASH_BE_W`=4, `FLASH_BURST`=6'd1.
- Sub-module `flash_rd_watchdog` (timeout counter with clear/enable/expired), instantiated only under `FLASH_RD_TIMEOUT_EN`.

## Test plan
- Zero-wait read: `start`=1, addr=0x00010, be=0xF, slave returns 0x1234_5678 one cycle after accept -> `flash_mem_address`=0x00010 in cycle 1, `done` in cycle 3, `data`=0x1234_5678, `err`=0.
- Stall: waitrequest high for 3 cycles, then data after 2 more cycles -> `flash_mem_read` held with a stable address for 4 cycles, `done` in cycle 8.
- Address change: change `address` to 0x7FFFF while in `WAIT_DATA` -> the in-flight read still uses 0x00010; the next read uses 0x7FFFF.
- Back-to-back: `start` held high across `done` -> a second `flash_mem_read` in the cycle after `IDLE`; two `done` pulses; `data` updates per read.
- Reset mid-read: assert `reset_n`=0 in `WAIT_DATA`, deliver `readdatavalid` after release -> no `done`; `data`=0.
- Timeout (macro on, `TIMEOUT_CYCLES`=8): no `readdatavalid` -> `done` and `err`=1 at 8 cycles after entering `WAIT_DATA`; `data` holds its previous value.

Source files
------------

// File: rtl/flash_rd_pkg.sv
// Shared types and widths for the flash word-read responder.
// Imported by flash_read_ctrl and flash_rd_watchdog.
package flash_rd_pkg;

   localparam int          FLASH_ADDR_W = 23;
   localparam int          FLASH_DATA_W = 32;
   localparam int          FLASH_BE_W   = 4;
   localparam logic [5:0]  FLASH_BURST  = 6'd1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      REQ       = 2'd1,
      WAIT_DATA = 2'd2,
      DONE      = 2'd3
   } flash_rd_state_t;

endpackage

// File: rtl/flash_rd_watchdog.sv
// Cycle counter that flags a stalled read response; only instantiated when
// FLASH_RD_TIMEOUT_EN is defined.
module flash_rd_watchdog
   import flash_rd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] count;

   // expired flags the last permitted waiting cycle, so the controller
   // leaves after exactly TIMEOUT_CYCLES cycles of waiting
   assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && !expired) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/flash_read_ctrl.sv
// Single-beat Avalon-MM read responder between the playback sequencer and the
// flash controller. Optional response timeout: define FLASH_RD_TIMEOUT_EN.
module flash_read_ctrl
   import flash_rd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [FLASH_ADDR_W-1:0] address,
   input  logic [FLASH_BE_W-1:0]   byteenable,
   output logic                    done,
   output logic [FLASH_DATA_W-1:0] data,
   output logic                    err,
   output logic                    flash_mem_read,
   output logic [FLASH_ADDR_W-1:0] flash_mem_address,
   output logic [FLASH_BE_W-1:0]   flash_mem_byteenable,
   output logic [5:0]              flash_mem_burstcount,
   input  logic                    flash_mem_waitrequest,
   input  logic [FLASH_DATA_W-1:0] flash_mem_readdata,
   input  logic                    flash_mem_readdatavalid
);

   flash_rd_state_t state;
   flash_rd_state_t state_nxt;

   logic cmd_load;
   logic data_load;
   logic err_nxt;
   logic timeout_hit;

   assign flash_mem_burstcount = FLASH_BURST;

`ifdef FLASH_RD_TIMEOUT_EN
   flash_rd_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (state != WAIT_DATA),
      .en      (state == WAIT_DATA),
      .expired (timeout_hit)
   );
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign timeout_hit        = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cmd_load  = 1'b0;
      data_load = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = REQ;
               cmd_load  = 1'b1;
            end
         end
         REQ: begin
            if (!flash_mem_waitrequest) begin
               state_nxt = WAIT_DATA;
            end
         end
         WAIT_DATA: begin
            // a response landing on the timeout cycle still completes normally
            if (flash_mem_readdatavalid) begin
               state_nxt = DONE;
               data_load = 1'b1;
            end else if (timeout_hit) begin
               state_nxt = DONE;
               err_nxt   = 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // outputs are registered from the next state so they line up with it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         done                 <= 1'b0;
         err                  <= 1'b0;
         data                 <= '0;
         flash_mem_read       <= 1'b0;
         flash_mem_address    <= '0;
         flash_mem_byteenable <= '0;
      end else begin
         done           <= (state_nxt == DONE);
         err            <= err_nxt;
         flash_mem_read <= (state_nxt == REQ);
         if (cmd_load) begin
            flash_mem_address    <= address;
            flash_mem_byteenable <= byteenable;
         end
         if (data_load) begin
            data <= flash_mem_readdata;
         end
      end
   end

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Scoreboard bench for flash_read_ctrl; timeout cases run when
// FLASH_RD_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 8).
module tb_flash_read_ctrl;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [22:0] address;
   logic [3:0]  byteenable;
   logic        done;
   logic [31:0] data;
   logic        err;
   logic        flash_mem_read;
   logic [22:0] flash_mem_address;
   logic [3:0]  flash_mem_byteenable;
   logic [5:0]  flash_mem_burstcount;
   logic        flash_mem_waitrequest;
   logic [31:0] flash_mem_readdata;
   logic        flash_mem_readdatavalid;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        e;
   int          n_vec  = 0;
   int          n_miss = 0;
   logic [31:0] last_data;

   flash_read_ctrl #(
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .start                   (start),
      .address                 (address),
      .byteenable              (byteenable),
      .done                    (done),
      .data                    (data),
      .err                     (err),
      .flash_mem_read          (flash_mem_read),
      .flash_mem_address       (flash_mem_address),
      .flash_mem_byteenable    (flash_mem_byteenable),
      .flash_mem_burstcount    (flash_mem_burstcount),
      .flash_mem_waitrequest   (flash_mem_waitrequest),
      .flash_mem_readdata      (flash_mem_readdata),
      .flash_mem_readdatavalid (flash_mem_readdatavalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_miss++;
         $display("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // every done pulse is matched against the oldest outstanding expectation
   always @(negedge clk) begin
      if (reset_n && done) begin
         if (sb_q.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("done_data", data, e.data);
            check("done_err", {31'd0, err}, {31'd0, e.err});
         end
      end
   end

   task automatic do_read(input logic [22:0] a, input logic [3:0] b, input logic [31:0] rd,
                          input int nw, input int nl, input bit keep,
                          input bit chg, input logic [22:0] ca);
      sb_q.push_back('{rd, 1'b0});
      address    = a;
      byteenable = b;
      start      = 1'b1;
      tick();
      for (int i = 0; i < nw; i++) begin
         flash_mem_waitrequest   = 1'b1;
         flash_mem_readdatavalid = (i == 0);
         flash_mem_readdata      = 32'hDEAD_BEEF;
         check("req_read", {31'd0, flash_mem_read}, 32'd1);
         check("req_addr_stable", {9'd0, flash_mem_address}, {9'd0, a});
         tick();
      end
      flash_mem_waitrequest   = 1'b0;
      flash_mem_readdatavalid = 1'b0;
      check("req_read", {31'd0, flash_mem_read}, 32'd1);
      check("req_addr", {9'd0, flash_mem_address}, {9'd0, a});
      check("req_be", {28'd0, flash_mem_byteenable}, {28'd0, b});
      tick();
      check("wait_read_low", {31'd0, flash_mem_read}, 32'd0);
      if (chg) begin
         address = ca;
         start   = 1'b0;
      end
      for (int i = 0; i < nl; i++) begin
         check("wait_no_done", {31'd0, done}, 32'd0);
         tick();
      end
      flash_mem_readdatavalid = 1'b1;
      flash_mem_readdata      = rd;
      tick();
      flash_mem_readdatavalid = 1'b0;
      flash_mem_readdata      = $urandom;
      check("done_cycle", {31'd0, done}, 32'd1);
      check("done_addr", {9'd0, flash_mem_address}, {9'd0, a});
      if (!keep) start = 1'b0;
      tick();
      check("done_pulse_end", {31'd0, done}, 32'd0);
      check("idle_read_low", {31'd0, flash_mem_read}, 32'd0);
      last_data = rd;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed hang expected finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      reset_n                 = 1'b0;
      start                   = 1'b0;
      address                 = '0;
      byteenable              = '0;
      flash_mem_waitrequest   = 1'b0;
      flash_mem_readdata      = '0;
      flash_mem_readdatavalid = 1'b0;
      last_data               = '0;
      tick();
      tick();
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_data", data, 32'd0);
      check("rst_read", {31'd0, flash_mem_read}, 32'd0);
      check("rst_addr", {9'd0, flash_mem_address}, 32'd0);
      check("rst_be", {28'd0, flash_mem_byteenable}, 32'd0);
      check("burstcount", {26'd0, flash_mem_burstcount}, 32'd1);
      reset_n = 1'b1;
      tick();

      // zero-wait, then stall (3 waitrequest + 2 latency cycles)
      do_read(23'h00010, 4'hF, 32'h1234_5678, 0, 0, 1'b0, 1'b0, 23'h0);
      do_read(23'h00123, 4'h5, 32'hCAFE_0001, 3, 2, 1'b0, 1'b0, 23'h0);

      // stray response while idle must be ignored
      flash_mem_readdatavalid = 1'b1;
      flash_mem_readdata      = 32'hBAD0_BAD0;
      tick();
      flash_mem_readdatavalid = 1'b0;
      tick();
      check("idle_rdv_ignored", data, last_data);

      // address change (and start drop) while the read is in flight
      do_read(23'h00010, 4'hF, 32'hA5A5_0F0F, 0, 2, 1'b0, 1'b1, 23'h7FFFF);
      do_read(23'h7FFFF, 4'h3, 32'h0BAD_F00D, 1, 1, 1'b0, 1'b0, 23'h0);

      // back-to-back with start held across done
      do_read(23'h00200, 4'hC, 32'h1111_2222, 0, 1, 1'b1, 1'b0, 23'h0);
      do_read(23'h00201, 4'h1, 32'h3333_4444, 0, 0, 1'b0, 1'b0, 23'h0);

      // reset while waiting for data, then a late response
      address = 23'h00300;
      start   = 1'b1;
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      check("midrst_read", {31'd0, flash_mem_read}, 32'd0);
      check("midrst_data", data, 32'd0);
      start = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      flash_mem_readdatavalid = 1'b1;
      flash_mem_readdata      = 32'h7777_8888;
      tick();
      flash_mem_readdatavalid = 1'b0;
      tick();
      tick();
      check("late_rdv_data", data, 32'd0);
      check("late_rdv_done", {31'd0, done}, 32'd0);
      last_data = '0;

      do_read(23'h00400, 4'hF, 32'h5555_AAAA, 0, 0, 1'b0, 1'b0, 23'h0);

`ifdef FLASH_RD_TIMEOUT_EN
      // response on the timeout cycle wins
      do_read(23'h00500, 4'hF, 32'h6666_9999, 0, 7, 1'b0, 1'b0, 23'h0);
      // no response: done with err after 8 waiting cycles, data held
      sb_q.push_back('{last_data, 1'b1});
      address = 23'h00600;
      start   = 1'b1;
      tick();
      tick();
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         check("to_no_early_done", {31'd0, done}, 32'd0);
         tick();
      end
      check("to_done", {31'd0, done}, 32'd1);
      tick();
      check("to_done_end", {31'd0, done}, 32'd0);
`else
      // without the timeout a long wait still completes normally
      do_read(23'h00500, 4'hF, 32'h6666_9999, 0, 12, 1'b0, 1'b0, 23'h0);
`endif

      tick();
      check("sb_empty", sb_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
